// File: rtl/trisc_hex_pkg.sv
// rtl/trisc_hex_pkg.sv - glyph table and shared types for the TRISC hex display
package trisc_hex_pkg;

  typedef logic [3:0] nibble_t;

  // Segment order gfedcba, active-low
  localparam logic [6:0] GLYPH_DARK = 7'b1111111;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/trisc_hex_display_if.sv
// rtl/trisc_hex_display_if.sv - host-side signal bundle of the TRISC hex display driver
interface trisc_hex_display_if #(
  parameter int NUM_DIGITS = 6
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blank_mask;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic                      lz_en;
  logic [7*NUM_DIGITS-1:0]   hex_out;
  logic [NUM_DIGITS-1:0]     dp_out;
  logic [6:0]                seg_mux;
  logic                      dp_mux;
  logic [NUM_DIGITS-1:0]     dig_sel;
  logic                      pending;
  logic                      upd_done;

  modport master (
    output load, value, dp_in, blank_mask, blink_mask, lz_en,
    input  hex_out, dp_out, seg_mux, dp_mux, dig_sel, pending, upd_done
  );

  modport slave (
    input  load, value, dp_in, blank_mask, blink_mask, lz_en,
    output hex_out, dp_out, seg_mux, dp_mux, dig_sel, pending, upd_done
  );

endinterface

// File: rtl/trisc_hex_glyph.sv
// rtl/trisc_hex_glyph.sv - nibble to active-low 7-segment glyph with dark override
module trisc_hex_glyph
  import trisc_hex_pkg::*;
(
  input  nibble_t    nib_i,
  input  logic       dark_i,
  output logic [6:0] seg_o
);

  assign seg_o = dark_i ? GLYPH_DARK : GLYPH_TABLE[nib_i];

endmodule

// File: rtl/trisc_hex_display.sv
// rtl/trisc_hex_display.sv - multi-digit hex display driver with static and scanned outputs
module trisc_hex_display
  import trisc_hex_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic               clk,
  input  logic               rst_n,
  trisc_hex_display_if.slave bus
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam int HW = 7 * NUM_DIGITS;
  localparam logic [DW-1:0] DIV_MAX   = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [VW-1:0]         pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                  pending_q, pending_d, upd_done_q, upd_done_d;
  logic [HW-1:0]         hex_q, hex_d;
  logic [NUM_DIGITS-1:0] dpo_q, dpo_d, dig_sel_q, dig_sel_d;
  logic [6:0]            seg_mux_q, seg_mux_d;
  logic                  dp_mux_q, dp_mux_d;

  logic                  tick, frame_end, lz_run;
  nibble_t               nib   [NUM_DIGITS];
  logic [6:0]            glyph [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dark, dp_lit, sel_n;
  logic [6:0]            mux_glyph;

  assign tick      = (div_cnt_q == DIV_MAX);
  assign frame_end = tick && (scan_idx_q == IDX_MAX);

  // lz_run stays high while every nibble from the top down to digit i is zero
  always_comb begin
    lz_run = bus.lz_en;
    dark   = '0;
    dp_lit = '0;
    sel_n  = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib[i]    = act_val_q[4*i +: 4];
      lz_run    = lz_run & (nib[i] == 4'h0);
      dark[i]   = bus.blank_mask[i] | (bus.blink_mask[i] & blink_ph_q) | ((i != 0) & lz_run);
      dp_lit[i] = act_dp_q[i] & ~dark[i];
      sel_n[i]  = (scan_idx_q != IW'(i));
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    trisc_hex_glyph u_glyph (
      .nib_i  (nib[g]),
      .dark_i (dark[g]),
      .seg_o  (glyph[g])
    );
  end

  trisc_hex_glyph u_glyph_mux (
    .nib_i  (nib[scan_idx_q]),
    .dark_i (dark[scan_idx_q]),
    .seg_o  (mux_glyph)
  );

  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + DW'(1);
    scan_idx_d  = scan_idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pending_d   = pending_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    upd_done_d  = 1'b0;
    seg_mux_d   = seg_mux_q;
    dp_mux_d    = dp_mux_q;
    dig_sel_d   = dig_sel_q;

    if (tick) begin
      scan_idx_d = frame_end ? '0 : scan_idx_q + IW'(1);
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
      seg_mux_d = mux_glyph;
      dp_mux_d  = ~dp_lit[scan_idx_q];
      dig_sel_d = sel_n;
    end

    // Promotion reads the old pending buffer before a same-cycle load overwrites it
    if (frame_end && pending_q) begin
      act_val_d  = pend_val_q;
      act_dp_d   = pend_dp_q;
      pending_d  = 1'b0;
      upd_done_d = 1'b1;
    end
    if (bus.load) begin
      pend_val_d = bus.value;
      pend_dp_d  = bus.dp_in;
      pending_d  = 1'b1;
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_d[7*i +: 7] = glyph[i];
    end
    dpo_d = ~dp_lit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      scan_idx_q  <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pending_q   <= 1'b0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      upd_done_q  <= 1'b0;
      hex_q       <= '1;
      dpo_q       <= '1;
      seg_mux_q   <= '1;
      dp_mux_q    <= 1'b1;
      dig_sel_q   <= '1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      scan_idx_q  <= scan_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pending_q   <= pending_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      upd_done_q  <= upd_done_d;
      hex_q       <= hex_d;
      dpo_q       <= dpo_d;
      seg_mux_q   <= seg_mux_d;
      dp_mux_q    <= dp_mux_d;
      dig_sel_q   <= dig_sel_d;
    end
  end

  assign bus.hex_out  = hex_q;
  assign bus.dp_out   = dpo_q;
  assign bus.seg_mux  = seg_mux_q;
  assign bus.dp_mux   = dp_mux_q;
  assign bus.dig_sel  = dig_sel_q;
  assign bus.pending  = pending_q;
  assign bus.upd_done = upd_done_q;

endmodule

// File: tb/tb_trisc_hex_display.sv
// tb/tb_trisc_hex_display.sv - self-checking bench for trisc_hex_display
module tb_trisc_hex_display;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  trisc_hex_display_if #(.NUM_DIGITS(N)) bus ();

  trisc_hex_display #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLINK_TICKS (BT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: position derived from edge count since reset release
  int          m_cyc;
  logic [15:0] m_act_v, m_pend_v;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pending;
  logic [27:0] e_hex;
  logic [3:0]  e_dp, e_sel;
  logic [6:0]  e_seg;
  logic        e_dpm, e_upd;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [27:0] hex;
    logic [3:0]  dpo;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic digit_dark(input int i, input logic ph);
    return bus.blank_mask[i] | (bus.blink_mask[i] & ph) |
           (bus.lz_en && (i != 0) && ((m_act_v >> (4 * i)) == 16'h0));
  endfunction

  task automatic model_reset();
    m_cyc = 0;  m_act_v = '0;  m_pend_v = '0;  m_act_dp = '0;  m_pend_dp = '0;
    m_pending = 1'b0;
    e_hex = '1;  e_dp = '1;  e_sel = '1;  e_seg = '1;  e_dpm = 1'b1;  e_upd = 1'b0;
  endtask

  // One clock: predict from pre-edge state and live inputs, then compare all outputs
  task automatic step();
    int   ticks, idx;
    logic tk, ph, boundary;
    ticks    = m_cyc / RD;
    tk       = (m_cyc % RD) == RD - 1;
    idx      = ticks % N;
    ph       = ((ticks / BT) % 2) == 1;
    boundary = tk && (idx == N - 1);
    for (int i = 0; i < N; i++) begin
      e_hex[7*i +: 7] = digit_dark(i, ph) ? 7'h7F : glyph_of(4'((m_act_v >> (4 * i)) & 16'hF));
      e_dp[i]         = digit_dark(i, ph) | ~m_act_dp[i];
    end
    if (tk) begin
      e_seg = e_hex[7*idx +: 7];
      e_dpm = e_dp[idx];
      e_sel = ~(4'b0001 << idx);
    end
    e_upd = boundary && m_pending;
    if (boundary && m_pending) begin
      m_act_v   = m_pend_v;
      m_act_dp  = m_pend_dp;
      m_pending = 1'b0;
    end
    if (bus.load) begin
      m_pend_v  = bus.value;
      m_pend_dp = bus.dp_in;
      m_pending = 1'b1;
    end
    m_cyc++;
    @(posedge clk);
    @(negedge clk);
    chk("sb_hex_out",  bus.hex_out,  e_hex);
    chk("sb_dp_out",   bus.dp_out,   e_dp);
    chk("sb_seg_mux",  bus.seg_mux,  e_seg);
    chk("sb_dp_mux",   bus.dp_mux,   e_dpm);
    chk("sb_dig_sel",  bus.dig_sel,  e_sel);
    chk("sb_pending",  bus.pending,  m_pending);
    chk("sb_upd_done", bus.upd_done, e_upd);
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_hex"},     bus.hex_out,  28'hFFFFFFF);
    chk({tag, "_dp"},      bus.dp_out,   4'hF);
    chk({tag, "_seg"},     bus.seg_mux,  7'h7F);
    chk({tag, "_dpm"},     bus.dp_mux,   1'b1);
    chk({tag, "_sel"},     bus.dig_sel,  4'hF);
    chk({tag, "_pending"}, bus.pending,  1'b0);
    chk({tag, "_upd"},     bus.upd_done, 1'b0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    check_dark("reset");
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic align(input int phase);
    for (int k = 0; k < 16 && (m_cyc % 16) != phase; k++) step();
  endtask

  task automatic load_apply(input string tag, input logic [15:0] v, input logic [3:0] dp);
    logic seen;
    bus.value = v;  bus.dp_in = dp;  bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      seen = bus.upd_done;
    end
    chk({tag, "_upd_seen"}, seen, 1'b1);
    step();
  endtask

  initial begin
    logic [3:0] seq [4];
    logic [6:0] prev;
    int         cnt;

    bus.load = 1'b0;  bus.value = '0;  bus.dp_in = '0;
    bus.blank_mask = '0;  bus.blink_mask = '0;  bus.lz_en = 1'b0;
    model_reset();

    vecs[0] = '{16'h1A3F, 4'b0000, 1'b0, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}, 4'b1111};
    vecs[1] = '{16'h0040, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111};
    vecs[4] = '{16'h7E62, 4'b1010, 1'b0, {7'b1111000, 7'b0000110, 7'b0000010, 7'b0100100}, 4'b0101};
    vecs[5] = '{16'h0D09, 4'b1111, 1'b1, {7'b1111111, 7'b0100001, 7'b1000000, 7'b0011000}, 4'b1000};

    // Reset state, then scan order after release
    do_reset();
    repeat (4) step();
    chk("t1_first_sel", bus.dig_sel, 4'b1110);
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    for (int k = 0; k < 4; k++) begin
      repeat (4) step();
      chk($sformatf("t1_sel%0d", k), bus.dig_sel, seq[k]);
    end

    // Decode table including leading-zero suppression
    for (int v = 0; v < 6; v++) begin
      bus.lz_en = vecs[v].lz;
      load_apply($sformatf("vec%0d", v), vecs[v].value, vecs[v].dp);
      chk($sformatf("vec%0d_hex", v), bus.hex_out, vecs[v].hex);
      chk($sformatf("vec%0d_dp", v),  bus.dp_out,  vecs[v].dpo);
    end
    bus.lz_en = 1'b0;

    // Two loads inside one frame: latest wins, single update
    align(1);
    bus.value = 16'h1111;  bus.load = 1'b1;  step();
    bus.load = 1'b0;  repeat (3) step();
    bus.value = 16'h2222;  bus.load = 1'b1;  step();
    bus.load = 1'b0;
    cnt = 0;
    repeat (20) begin step(); cnt += int'(bus.upd_done); end
    chk("t4_upd_count", cnt, 1);
    chk("t4_hex", bus.hex_out, {4{7'b0100100}});

    // Load on the boundary cycle while pending is set
    align(2);
    bus.value = 16'h3333;  bus.load = 1'b1;  step();
    bus.load = 1'b0;
    align(15);
    bus.value = 16'h4444;  bus.load = 1'b1;  step();
    bus.load = 1'b0;
    cnt = int'(bus.upd_done);
    chk("t5_pending_kept", bus.pending, 1'b1);
    step();
    chk("t5_hex_3333", bus.hex_out, {4{7'b0110000}});
    repeat (17) begin step(); cnt += int'(bus.upd_done); end
    chk("t5_upd_count", cnt, 2);
    chk("t5_hex_4444", bus.hex_out, {4{7'b0011001}});
    chk("t5_pending_clr", bus.pending, 1'b0);

    // Blink on digit 0: four toggles in 32 clocks
    load_apply("t6", 16'h0005, 4'b0000);
    bus.blink_mask = 4'b0001;
    repeat (2) step();
    prev = bus.hex_out[6:0];
    cnt  = 0;
    repeat (32) begin
      step();
      if (bus.hex_out[6:0] != prev) cnt++;
      prev = bus.hex_out[6:0];
    end
    chk("t6_toggles", cnt, 4);
    bus.blink_mask = 4'b0000;

    // Asynchronous reset mid-frame with a pending value
    bus.value = 16'h6666;  bus.load = 1'b1;  step();
    bus.load = 1'b0;  repeat (2) step();
    #2 rst_n = 1'b0;
    #1 check_dark("t6_async");
    do_reset();
    repeat (4) step();
    chk("t6_restart_sel", bus.dig_sel, 4'b1110);
    chk("t6_restart_hex", bus.hex_out, {4{7'b1000000}});

    // Randomised traffic against the reference
    for (int r = 0; r < 400; r++) begin
      bus.load       = ($urandom_range(0, 7) == 0);
      bus.value      = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      bus.dp_in      = 4'($urandom);
      bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      bus.blink_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if ((r % 50) == 0) bus.lz_en = 1'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
